// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_KILL = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus4;
  } ifid_t;

  // Sequential PC, wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Request/grant/response channel between the fetch stage and instruction memory.
interface fetch_stage_if;
  import mips_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble has priority over load, otherwise hold.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            bubble,
  input  ifid_t           d,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pcplus4,
  output logic            valid
);

  // A bubble keeps PCPlus4D so downstream debug sees the last real PC+4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr   <= NOP_INSTR;
      pcplus4 <= '0;
      valid   <= 1'b0;
    end else if (bubble) begin
      instr   <= NOP_INSTR;
      valid   <= 1'b0;
    end else if (load) begin
      instr   <= d.instr;
      pcplus4 <= d.pcplus4;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem FSM, skid buffer and IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             PCSrcD,
  input  logic [XLEN-1:0]  PCBranchD,
  fetch_stage_if.master    imem,
  output logic [XLEN-1:0]  InstrD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic             ValidD,
  output logic [XLEN-1:0]  PCF
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] skid_q, skid_d;
  logic            kill_q, kill_d;
  logic            req_q;

  logic            advance;
  logic            redirect;
  logic            ifid_load;
  logic            ifid_bubble;
  ifid_t           ifid_d;

  assign advance  = StallF & StallD;
  assign redirect = PCSrcD & StallD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pcf_q      <= RESET_PC;
      req_addr_q <= '0;
      skid_q     <= '0;
      kill_q     <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      req_addr_q <= req_addr_d;
      skid_q     <= skid_d;
      kill_q     <= kill_d;
      req_q      <= (state_d == ST_REQ);
    end
  end

  // kill_q remembers a redirect seen while a request was still waiting for grant.
  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    req_addr_d   = req_addr_q;
    skid_d       = skid_q;
    kill_d       = kill_q;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    ifid_d       = '{instr: imem.imem_rdata, pcplus4: pc_plus4(req_addr_q)};

    if (redirect) pcf_d = PCBranchD;

    unique case (state_q)
      ST_BOOT: state_d = ST_REQ;

      ST_REQ: begin
        if (imem.imem_gnt) begin
          state_d = (redirect || kill_q) ? ST_KILL : ST_WAIT;
          kill_d  = 1'b0;
        end else if (redirect) begin
          kill_d  = 1'b1;
        end
      end

      ST_WAIT: begin
        if (imem.imem_rvalid) begin
          if (redirect) begin
            state_d = ST_REQ;
          end else if (advance) begin
            ifid_load = 1'b1;
            pcf_d     = pc_plus4(req_addr_q);
            state_d   = ST_REQ;
          end else begin
            skid_d    = imem.imem_rdata;
            state_d   = ST_HOLD;
          end
        end else if (redirect) begin
          state_d = ST_KILL;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_REQ;
        end else if (advance) begin
          ifid_load    = 1'b1;
          ifid_d.instr = skid_q;
          pcf_d        = pc_plus4(req_addr_q);
          state_d      = ST_REQ;
        end
      end

      ST_KILL: begin
        if (imem.imem_rvalid) state_d = ST_REQ;
      end

      default: state_d = ST_BOOT;
    endcase

    // The request address is latched from the (next) PC only when a new request starts.
    if (state_d == ST_REQ && state_q != ST_REQ) req_addr_d = pcf_d;

    if (redirect) begin
      ifid_load   = 1'b0;
      ifid_bubble = 1'b1;
    end else if (advance && !ifid_load) begin
      ifid_bubble = 1'b1;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ifid_load),
    .bubble  (ifid_bubble),
    .d       (ifid_d),
    .instr   (InstrD),
    .pcplus4 (PCPlus4D),
    .valid   (ValidD)
  );

  assign PCF            = pcf_q;
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = req_addr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stalls/redirects.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, StallD, PCSrcD;
  logic [31:0] PCBranchD;
  logic [31:0] InstrD, PCPlus4D, PCF;
  logic        ValidD;

  int checks   = 0;
  int failures = 0;
  int deliv    = 0;

  // Memory responder knobs
  int lat       = 1;
  int gdel      = 0;
  bit rnd       = 1'b0;

  fetch_stage_if imem();

  fetch_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallF    (StallF),
    .StallD    (StallD),
    .PCSrcD    (PCSrcD),
    .PCBranchD (PCBranchD),
    .imem      (imem),
    .InstrD    (InstrD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .PCF       (PCF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return a ^ 32'hA5C3_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (imem.imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (imem.imem_req !== 1'b1) timeout(tag);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (ValidD !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (ValidD !== 1'b1) timeout(tag);
  endtask

  // Instruction memory: grant after gdel cycles, one in-order response lat cycles later.
  initial begin
    bit          r_req = 1'b0;
    logic [31:0] r_addr = '0;
    bit          pend = 1'b0;
    logic [31:0] paddr = '0;
    int          cnt = 0;
    int          wcnt = 0;
    int          gd = 0;
    imem.imem_gnt    = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (imem.imem_rvalid) pend = 1'b0;
      imem.imem_rvalid = 1'b0;
      if (imem.imem_gnt && r_req) begin
        pend  = 1'b1;
        paddr = r_addr;
        cnt   = rnd ? int'($urandom_range(1, 4)) : lat;
        gd    = rnd ? int'($urandom_range(0, 2)) : gdel;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem.imem_rvalid = 1'b1;
          imem.imem_rdata  = mem_word(paddr);
        end
      end
      if (imem.imem_req) begin
        if (wcnt >= gd) begin
          imem.imem_gnt = 1'b1;
          wcnt = 0;
        end else begin
          imem.imem_gnt = 1'b0;
          wcnt++;
        end
      end else begin
        imem.imem_gnt = 1'b0;
      end
      r_req  = imem.imem_req;
      r_addr = imem.imem_addr;
    end
  end

  // Reference model: the program-order PC stream, reset to 0 and redirected by honoured branches.
  initial begin
    logic [31:0] exp_pc = '0;
    logic [31:0] p_instr = '0, p_p4 = '0, p_addr = '0;
    logic        p_valid = 1'b0, p_req = 1'b0;
    bit          adv, rdr;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        exp_pc = '0; p_instr = '0; p_p4 = '0; p_valid = 1'b0; p_req = 1'b0; p_addr = '0;
      end else begin
        adv = StallF && StallD;
        rdr = PCSrcD && StallD;
        if (rdr) begin
          chk("m_redir_valid", 32'(ValidD), 32'h0);
          chk("m_redir_instr", InstrD, 32'h0);
          chk("m_redir_p4", PCPlus4D, p_p4);
          exp_pc = PCBranchD;
        end else if (adv) begin
          if (ValidD) begin
            chk("m_instr", InstrD, mem_word(exp_pc));
            chk("m_p4", PCPlus4D, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            deliv++;
          end else begin
            chk("m_bubble_instr", InstrD, 32'h0);
            chk("m_bubble_p4", PCPlus4D, p_p4);
          end
        end else begin
          chk("m_hold_instr", InstrD, p_instr);
          chk("m_hold_p4", PCPlus4D, p_p4);
          chk("m_hold_valid", 32'(ValidD), 32'(p_valid));
        end
        chk("m_pcf", PCF, exp_pc);
        if (p_req && !imem.imem_gnt && imem.imem_req)
          chk("m_addr_stable", imem.imem_addr, p_addr);
        p_instr = InstrD; p_p4 = PCPlus4D; p_valid = ValidD;
        p_req = imem.imem_req; p_addr = imem.imem_addr;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, pcf0, old_instr, old_p4, r;
    int          bubbles, moved, d0;
    rst_n = 1'b0; StallF = 1'b1; StallD = 1'b1; PCSrcD = 1'b0; PCBranchD = '0;

    // Reset and boot
    repeat (3) @(negedge clk);
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_instr", InstrD, 32'h0);
    chk("rst_p4", PCPlus4D, 32'h0);
    chk("rst_valid", 32'(ValidD), 32'h0);
    chk("rst_req", 32'(imem.imem_req), 32'h0);
    chk("rst_addr", imem.imem_addr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_req", 32'(imem.imem_req), 32'h1);
    chk("boot_addr", imem.imem_addr, 32'h0);
    @(negedge clk);
    chk("wait_req_low", 32'(imem.imem_req), 32'h0);
    @(negedge clk);
    chk("first_instr", InstrD, 32'h2008_0005);
    chk("first_p4", PCPlus4D, 32'h4);
    chk("first_valid", 32'(ValidD), 32'h1);
    chk("second_addr", imem.imem_addr, 32'h4);

    // Slow memory: three bubbles, PC moves once
    lat = 3;
    pcf0 = PCF; bubbles = 0; moved = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ValidD) break;
      bubbles++;
      if (PCF !== pcf0) moved++;
    end
    chk("slow_bubbles", 32'(bubbles), 32'd3);
    chk("slow_pc_moved", 32'(moved), 32'd0);
    chk("slow_pcf", PCF, pcf0 + 32'd4);
    chk("slow_instr", InstrD, mem_word(32'h4));
    lat = 1;

    // Response lands while stalled: skid buffer, no new request
    wait_req("skid_wait_req");
    a = imem.imem_addr; old_instr = InstrD; old_p4 = PCPlus4D;
    StallF = 1'b0; StallD = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("skid_req_low", 32'(imem.imem_req), 32'h0);
    chk("skid_hold_instr", InstrD, old_instr);
    @(negedge clk);
    chk("skid_req_low2", 32'(imem.imem_req), 32'h0);
    chk("skid_hold_p4", PCPlus4D, old_p4);
    StallF = 1'b1; StallD = 1'b1;
    @(negedge clk);
    chk("skid_instr", InstrD, mem_word(a));
    chk("skid_p4", PCPlus4D, a + 32'd4);
    chk("skid_valid", 32'(ValidD), 32'h1);
    chk("skid_next_addr", imem.imem_addr, a + 32'd4);

    // Redirect while a request is outstanding
    lat = 3;
    @(negedge clk);
    chk("rdw_in_wait", 32'(imem.imem_req), 32'h0);
    PCSrcD = 1'b1; PCBranchD = 32'h0000_0040;
    @(negedge clk);
    PCSrcD = 1'b0;
    chk("rdw_valid", 32'(ValidD), 32'h0);
    chk("rdw_pcf", PCF, 32'h40);
    wait_req("rdw_wait_req");
    chk("rdw_addr", imem.imem_addr, 32'h40);
    lat = 1;
    wait_valid("rdw_wait_valid");
    chk("rdw_instr", InstrD, mem_word(32'h40));
    chk("rdw_p4", PCPlus4D, 32'h44);

    // Redirect ignored while decode is stalled
    pcf0 = PCF;
    StallF = 1'b1; StallD = 1'b0; PCSrcD = 1'b1; PCBranchD = 32'h0000_0100;
    @(negedge clk);
    chk("ign_pcf", PCF, pcf0);
    StallD = 1'b1; PCSrcD = 1'b0;

    // Redirect coinciding with an advancing response
    wait_req("sim_wait_req");
    @(negedge clk);
    PCSrcD = 1'b1; PCBranchD = 32'h0000_0080;
    @(negedge clk);
    chk("sim_valid", 32'(ValidD), 32'h0);
    chk("sim_instr", InstrD, 32'h0);
    chk("sim_pcf", PCF, 32'h80);
    chk("sim_req", 32'(imem.imem_req), 32'h1);
    chk("sim_addr", imem.imem_addr, 32'h80);

    // Redirect on the grant cycle, to the top of the address space
    PCBranchD = 32'hFFFF_FFFC;
    @(negedge clk);
    PCSrcD = 1'b0;
    wait_valid("wrap_wait_valid");
    chk("wrap_instr", InstrD, mem_word(32'hFFFF_FFFC));
    chk("wrap_p4", PCPlus4D, 32'h0);
    chk("wrap_next_addr", imem.imem_addr, 32'h0);

    // Asynchronous reset in the middle of a wait
    wait_req("ar_wait_req");
    lat = 3;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(ValidD), 32'h0);
    chk("ar_instr", InstrD, 32'h0);
    chk("ar_p4", PCPlus4D, 32'h0);
    chk("ar_pcf", PCF, 32'h0);
    chk("ar_req", 32'(imem.imem_req), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 1;
    wait_valid("ar_wait_valid");
    chk("ar_instr_after", InstrD, 32'h2008_0005);
    chk("ar_p4_after", PCPlus4D, 32'h4);

    // Randomized stalls, redirects and memory timing
    rnd = 1'b1;
    d0 = deliv;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      StallF = ($urandom_range(0, 9) != 0);
      StallD = ($urandom_range(0, 9) != 0);
      PCSrcD = ($urandom_range(0, 19) == 0);
      r = $urandom;
      PCBranchD = r;
    end
    @(negedge clk);
    StallF = 1'b1; StallD = 1'b1; PCSrcD = 1'b0;
    rnd = 1'b0;
    repeat (10) @(negedge clk);
    chk("rand_progress", 32'(deliv - d0 >= 50), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
